// File: rtl/bell_ctrl_57_if.sv
// Bell controller bus: time-of-day, alarm settings, keys and sound outputs.
//   master : time/key source (drives tick, time, alarm settings, keys)
//   slave  : bell controller (drives sound_e/sound_model/snooze_pend)
interface bell_ctrl_57_if;
    logic       tick_1hz_57;
    logic [4:0] hour_57;
    logic [5:0] min_57;
    logic [5:0] sec_57;
    logic [4:0] alarm_hour_57;
    logic [5:0] alarm_min_57;
    logic       alarm_en_57;
    logic       stop_57;
    logic       snooze_57;
    logic       sound_e_57;
    logic       sound_model_57;
    logic       snooze_pend_57;

    modport master (
        output tick_1hz_57, hour_57, min_57, sec_57,
        output alarm_hour_57, alarm_min_57, alarm_en_57,
        output stop_57, snooze_57,
        input  sound_e_57, sound_model_57, snooze_pend_57
    );

    modport slave (
        input  tick_1hz_57, hour_57, min_57, sec_57,
        input  alarm_hour_57, alarm_min_57, alarm_en_57,
        input  stop_57, snooze_57,
        output sound_e_57, sound_model_57, snooze_pend_57
    );
endinterface

// File: rtl/bell_ctrl_57.sv
// Hourly chime / alarm clock bell controller.
//   clk_50m_57 : system clock
//   rst_57     : asynchronous active-high reset
//   bus        : slave side of bell_ctrl_57_if (tick, time, alarm settings,
//                stop/snooze keys in; sound_e/sound_model/snooze_pend out)
// States: IDLE (silent), CHIME (hourly chime), ALARM (alarm burst),
// SNOOZE (silent countdown back to ALARM). Outputs are registered and
// updated on the same edge as the state.
module bell_ctrl_57 #(
    parameter int unsigned CHIME_SEC  = 8,
    parameter int unsigned ALARM_SEC  = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic         clk_50m_57,
    input  logic         rst_57,
    bell_ctrl_57_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHIME  = 2'd1,
        ST_ALARM  = 2'd2,
        ST_SNOOZE = 2'd3
    } state_t;

    localparam logic [8:0] CHIME_CNT  = 9'(CHIME_SEC);
    localparam logic [8:0] ALARM_CNT  = 9'(ALARM_SEC);
    localparam logic [8:0] SNOOZE_CNT = 9'(SNOOZE_SEC);
    localparam logic [2:0] SNOOZE_MAX = 3'(MAX_SNOOZE);

    state_t     state;
    logic [8:0] count;
    logic [2:0] snooze_cnt;

    // Key edge detection. keys_live stays low for the first clock after
    // reset so a key held through reset only loads the registered copy.
    logic       keys_live;
    logic       stop_q;
    logic       snooze_q;

    logic       sound_e;
    logic       sound_model;
    logic       snooze_pend;

    logic       chime_trig;
    logic       alarm_trig;
    logic       stop_edge;
    logic       snooze_edge;
    logic       tick_last;

    // Output pattern for a given state: {sound_e, sound_model, snooze_pend}
    function automatic logic [2:0] outs_for(input state_t s);
        case (s)
            ST_CHIME:  outs_for = 3'b110;
            ST_ALARM:  outs_for = 3'b100;
            ST_SNOOZE: outs_for = 3'b001;
            default:   outs_for = 3'b000;
        endcase
    endfunction

    always_comb begin
        chime_trig  = bus.tick_1hz_57 && (bus.min_57 == '0) && (bus.sec_57 == '0);
        alarm_trig  = bus.tick_1hz_57 && bus.alarm_en_57 &&
                      (bus.hour_57 == bus.alarm_hour_57) &&
                      (bus.min_57 == bus.alarm_min_57) &&
                      (bus.sec_57 == '0);
        stop_edge   = keys_live && bus.stop_57 && !stop_q;
        // Simultaneous stop and snooze presses count as stop only.
        snooze_edge = keys_live && bus.snooze_57 && !snooze_q && !stop_edge;
        tick_last   = bus.tick_1hz_57 && (count == 9'd1);
    end

    always_ff @(posedge clk_50m_57 or posedge rst_57) begin
        if (rst_57) begin
            state       <= ST_IDLE;
            count       <= '0;
            snooze_cnt  <= '0;
            keys_live   <= 1'b0;
            stop_q      <= 1'b0;
            snooze_q    <= 1'b0;
            sound_e     <= 1'b0;
            sound_model <= 1'b0;
            snooze_pend <= 1'b0;
        end else begin
            keys_live <= 1'b1;
            stop_q    <= bus.stop_57;
            snooze_q  <= bus.snooze_57;

            case (state)
                ST_IDLE: begin
                    // Alarm takes priority over a coincident chime.
                    if (alarm_trig) begin
                        state      <= ST_ALARM;
                        count      <= ALARM_CNT;
                        snooze_cnt <= '0;
                        {sound_e, sound_model, snooze_pend} <= outs_for(ST_ALARM);
                    end else if (chime_trig) begin
                        state <= ST_CHIME;
                        count <= CHIME_CNT;
                        {sound_e, sound_model, snooze_pend} <= outs_for(ST_CHIME);
                    end
                end

                ST_CHIME: begin
                    if (alarm_trig) begin
                        state      <= ST_ALARM;
                        count      <= ALARM_CNT;
                        snooze_cnt <= '0;
                        {sound_e, sound_model, snooze_pend} <= outs_for(ST_ALARM);
                    end else if (stop_edge || tick_last) begin
                        state <= ST_IDLE;
                        {sound_e, sound_model, snooze_pend} <= outs_for(ST_IDLE);
                    end else if (bus.tick_1hz_57 && count > 9'd1) begin
                        count <= count - 9'd1;
                    end
                end

                ST_ALARM: begin
                    if (stop_edge) begin
                        state <= ST_IDLE;
                        {sound_e, sound_model, snooze_pend} <= outs_for(ST_IDLE);
                    end else if (snooze_edge && snooze_cnt < SNOOZE_MAX) begin
                        state      <= ST_SNOOZE;
                        count      <= SNOOZE_CNT;
                        snooze_cnt <= snooze_cnt + 3'd1;
                        {sound_e, sound_model, snooze_pend} <= outs_for(ST_SNOOZE);
                    end else if (!bus.alarm_en_57 || tick_last) begin
                        // A snooze press beyond the limit falls through here
                        // and is otherwise ignored.
                        state <= ST_IDLE;
                        {sound_e, sound_model, snooze_pend} <= outs_for(ST_IDLE);
                    end else if (bus.tick_1hz_57 && count > 9'd1) begin
                        count <= count - 9'd1;
                    end
                end

                ST_SNOOZE: begin
                    if (stop_edge || !bus.alarm_en_57) begin
                        state <= ST_IDLE;
                        {sound_e, sound_model, snooze_pend} <= outs_for(ST_IDLE);
                    end else if (tick_last) begin
                        // Re-ring keeps snooze_cnt so the limit spans the event.
                        state <= ST_ALARM;
                        count <= ALARM_CNT;
                        {sound_e, sound_model, snooze_pend} <= outs_for(ST_ALARM);
                    end else if (bus.tick_1hz_57 && count > 9'd1) begin
                        count <= count - 9'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                    {sound_e, sound_model, snooze_pend} <= outs_for(ST_IDLE);
                end
            endcase
        end
    end

    assign bus.sound_e_57     = sound_e;
    assign bus.sound_model_57 = sound_model;
    assign bus.snooze_pend_57 = snooze_pend;

endmodule

// File: tb/tb_bell_ctrl_57.sv
// Self-checking bench for bell_ctrl_57. Expected output patterns
// {sound_e, sound_model, snooze_pend} are queued as each stimulus cycle is
// driven and compared once the DUT has clocked that cycle.
module tb_bell_ctrl_57;

    localparam logic [2:0] O_IDLE   = 3'b000;
    localparam logic [2:0] O_CHIME  = 3'b110;
    localparam logic [2:0] O_ALARM  = 3'b100;
    localparam logic [2:0] O_SNOOZE = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    bell_ctrl_57_if bus_if ();

    bell_ctrl_57 #(
        .CHIME_SEC  (8),
        .ALARM_SEC  (60),
        .SNOOZE_SEC (300),
        .MAX_SNOOZE (3)
    ) dut (
        .clk_50m_57 (clk),
        .rst_57     (rst),
        .bus        (bus_if)
    );

    typedef struct {
        string      tag;
        logic [2:0] v;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [2:0]  obs;

    assign obs = {bus_if.sound_e_57, bus_if.sound_model_57, bus_if.snooze_pend_57};

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b, required %b", tag, got, exp);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        bus_if.hour_57 = 5'(h);
        bus_if.min_57  = 6'(m);
        bus_if.sec_57  = 6'(s);
    endtask

    task automatic set_alarm(input int h, input int m, input logic en);
        bus_if.alarm_hour_57 = 5'(h);
        bus_if.alarm_min_57  = 6'(m);
        bus_if.alarm_en_57   = en;
    endtask

    // One clock of stimulus; the expected pattern is queued on drive and
    // checked just after the edge that consumes it.
    task automatic cycle(input string tag, input logic t, input logic st,
                         input logic sn, input logic [2:0] exp);
        exp_t e;
        @(negedge clk);
        bus_if.tick_1hz_57 = t;
        bus_if.stop_57     = st;
        bus_if.snooze_57   = sn;
        sb.push_back('{tag, exp});
        @(posedge clk);
        #1;
        bus_if.tick_1hz_57 = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", obs, 3'bxxx);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.v);
        end
    endtask

    // n ticks at a non-trigger time, each preceded by a quiet cycle.
    task automatic ticks(input string tag, input int n,
                         input logic [2:0] mid, input logic [2:0] last);
        for (int i = 1; i <= n; i++) begin
            cycle(tag, 1'b0, 1'b0, 1'b0, mid);
            cycle(tag, 1'b1, 1'b0, 1'b0, (i == n) ? last : mid);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        bus_if.tick_1hz_57 = 1'b0;
        bus_if.stop_57     = 1'b0;
        bus_if.snooze_57   = 1'b0;
        set_time(0, 0, 1);
        set_alarm(0, 0, 1'b0);
        #25;
        chk("reset_state", obs, O_IDLE);
        #10;
        rst = 1'b0;

        // Hourly chime, alarm disarmed.
        cycle("idle_after_rst", 1'b0, 1'b0, 1'b0, O_IDLE);
        set_time(9, 59, 59);
        cycle("pre_chime", 1'b1, 1'b0, 1'b0, O_IDLE);
        set_time(10, 0, 0);
        cycle("chime_start", 1'b1, 1'b0, 1'b0, O_CHIME);
        set_time(10, 0, 1);
        ticks("chime_len", 8, O_CHIME, O_IDLE);

        // Alarm 07:30 with no keys runs its full burst.
        set_alarm(7, 30, 1'b1);
        set_time(7, 30, 0);
        cycle("alarm_start", 1'b1, 1'b0, 1'b0, O_ALARM);
        set_time(7, 30, 1);
        ticks("alarm_len", 60, O_ALARM, O_IDLE);

        // Alarm coinciding with the hourly chime wins; dropping enable ends it.
        set_alarm(8, 0, 1'b1);
        set_time(7, 59, 59);
        cycle("pre_coincide", 1'b1, 1'b0, 1'b0, O_IDLE);
        set_time(8, 0, 0);
        cycle("coincide_alarm", 1'b1, 1'b0, 1'b0, O_ALARM);
        set_time(8, 0, 1);
        cycle("coincide_hold", 1'b1, 1'b0, 1'b0, O_ALARM);
        bus_if.alarm_en_57 = 1'b0;
        cycle("alarm_en_drop", 1'b0, 1'b0, 1'b0, O_IDLE);
        bus_if.alarm_en_57 = 1'b1;

        // Alarm trigger preempts a running chime; stop ends the alarm.
        set_alarm(12, 1, 1'b1);
        set_time(12, 0, 0);
        cycle("chime_for_preempt", 1'b1, 1'b0, 1'b0, O_CHIME);
        set_time(12, 0, 1);
        cycle("chime_running", 1'b1, 1'b0, 1'b0, O_CHIME);
        set_time(12, 1, 0);
        cycle("alarm_preempt", 1'b1, 1'b0, 1'b0, O_ALARM);
        cycle("stop_alarm", 1'b0, 1'b1, 1'b0, O_IDLE);
        cycle("stop_release", 1'b0, 1'b0, 1'b0, O_IDLE);

        // Three snoozes allowed, fourth ignored.
        set_alarm(6, 15, 1'b1);
        set_time(6, 15, 0);
        cycle("snz_alarm", 1'b1, 1'b0, 1'b0, O_ALARM);
        set_time(6, 15, 1);
        for (int k = 0; k < 3; k++) begin
            cycle("snz_press", 1'b0, 1'b0, 1'b1, O_SNOOZE);
            cycle("snz_release", 1'b0, 1'b0, 1'b0, O_SNOOZE);
            ticks("snz_len", 300, O_SNOOZE, O_ALARM);
        end
        cycle("snz_4th_press", 1'b0, 1'b0, 1'b1, O_ALARM);
        cycle("snz_4th_release", 1'b0, 1'b0, 1'b0, O_ALARM);
        ticks("rering_len", 60, O_ALARM, O_IDLE);

        // Stop and snooze together act as stop.
        set_time(6, 15, 0);
        cycle("both_alarm", 1'b1, 1'b0, 1'b0, O_ALARM);
        set_time(6, 15, 1);
        cycle("both_keys", 1'b0, 1'b1, 1'b1, O_IDLE);
        cycle("both_release", 1'b0, 1'b0, 1'b0, O_IDLE);

        // Chime ignored during snooze; enable drop ends snooze.
        set_alarm(12, 59, 1'b1);
        set_time(12, 59, 0);
        cycle("snz2_alarm", 1'b1, 1'b0, 1'b0, O_ALARM);
        cycle("snz2_press", 1'b0, 1'b0, 1'b1, O_SNOOZE);
        cycle("snz2_release", 1'b0, 1'b0, 1'b0, O_SNOOZE);
        set_time(13, 0, 0);
        cycle("snz_chime_ignored", 1'b1, 1'b0, 1'b0, O_SNOOZE);
        bus_if.alarm_en_57 = 1'b0;
        cycle("snz_en_drop", 1'b0, 1'b0, 1'b0, O_IDLE);

        // Asynchronous reset in the middle of a chime, snooze key held.
        set_time(14, 0, 0);
        cycle("rst_chime_on", 1'b1, 1'b0, 1'b1, O_CHIME);
        set_time(14, 0, 1);
        cycle("rst_chime_run", 1'b1, 1'b0, 1'b1, O_CHIME);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async", obs, O_IDLE);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 3; k++)
            cycle("post_rst_quiet", 1'b1, 1'b0, 1'b1, O_IDLE);

        // First trigger after reset is honoured; held key gives no edge.
        set_alarm(14, 5, 1'b1);
        set_time(14, 5, 0);
        cycle("post_rst_alarm", 1'b1, 1'b0, 1'b1, O_ALARM);
        set_time(14, 5, 1);
        cycle("held_snooze", 1'b0, 1'b0, 1'b1, O_ALARM);
        cycle("held_release", 1'b0, 1'b0, 1'b0, O_ALARM);
        cycle("fresh_snooze", 1'b0, 1'b0, 1'b1, O_SNOOZE);
        cycle("snz_stop", 1'b0, 1'b1, 1'b0, O_IDLE);
        cycle("final_release", 1'b0, 1'b0, 1'b0, O_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bell_ctrl_57.md
BELL_CTRL_57 -- requirements
Module: bell_ctrl_57

Interface
REQ-001 Parameter CHIME_SEC, default 8, length of the hourly chime in 1 Hz ticks (1..63).
REQ-002 Parameter ALARM_SEC, default 60, length of one alarm burst in ticks (1..511).
REQ-003 Parameter SNOOZE_SEC, default 300, snooze delay in ticks (1..511).
REQ-004 Parameter MAX_SNOOZE, default 3, number of snoozes allowed per alarm event (0..7).
REQ-005 clk_50m_57  in  1  system clock, sole clock of the block.
REQ-006 rst_57  in  1  reset, asynchronous, active-high.
REQ-007 tick_1hz_57  in  1  one-cycle pulse once per second, synchronous to clk_50m_57.
REQ-008 hour_57  in  5  current hour, 0..23.
REQ-009 min_57  in  6  current minute, 0..59.
REQ-010 sec_57  in  6  current second, 0..59.
REQ-011 alarm_hour_57  in  5  alarm hour, 0..23.
REQ-012 alarm_min_57  in  6  alarm minute, 0..59.
REQ-013 alarm_en_57  in  1  alarm armed (level).
REQ-014 stop_57  in  1  debounced stop key, level, active-high.
REQ-015 snooze_57  in  1  debounced snooze key, level, active-high.
REQ-016 sound_e_57  out  1  sound/LED enable for the downstream buzzer and LED stages.
REQ-017 sound_model_57  out  1  0 = alarm pattern, 1 = hourly chime pattern.
REQ-018 snooze_pend_57  out  1  high while a snooze countdown is running.

Function
REQ-019 The FSM SHALL have states IDLE, CHIME, ALARM, SNOOZE.
REQ-020 Chime trigger SHALL be tick_1hz_57 & min_57==0 & sec_57==0.
REQ-021 Alarm trigger SHALL be tick_1hz_57 & alarm_en_57 & hour_57==alarm_hour_57 & min_57==alarm_min_57 & sec_57==0.
REQ-022 Key presses SHALL be the rising edges of stop_57/snooze_57, detected against a registered copy; a key held across reset SHALL NOT produce an edge.
REQ-023 IDLE: alarm trigger -> ALARM, count=ALARM_SEC, snooze_cnt=0; else chime trigger -> CHIME, count=CHIME_SEC.
REQ-024 Alarm and chime triggers in the same cycle SHALL enter ALARM (alarm wins).
REQ-025 CHIME: alarm trigger -> ALARM (preempts, count=ALARM_SEC, snooze_cnt=0); stop edge -> IDLE; otherwise each tick decrements count, and a tick with count==1 -> IDLE.
REQ-026 ALARM: stop edge -> IDLE; snooze edge with snooze_cnt<MAX_SNOOZE -> SNOOZE, count=SNOOZE_SEC, snooze_cnt+1; snooze edge with snooze_cnt==MAX_SNOOZE ignored; alarm_en_57 low -> IDLE; tick with count==1 -> IDLE; other ticks decrement count.
REQ-027 SNOOZE: stop edge or alarm_en_57 low -> IDLE; tick with count==1 -> ALARM, count=ALARM_SEC; other ticks decrement; chime triggers ignored.
REQ-028 Stop and snooze edges in the same cycle SHALL be treated as stop only.
REQ-029 The entry cycle SHALL NOT decrement count, so a burst of N spans exactly N ticks after entry.
REQ-030 count SHALL be 9 bits and SHALL never wrap below 1 in an active state; snooze_cnt SHALL be 3 bits and saturate at MAX_SNOOZE.
REQ-031 Outputs SHALL be registered and SHALL change on the clock edge on which the state changes (one cycle after the trigger cycle).
REQ-032 sound_e_57 SHALL be 1 in CHIME and ALARM and 0 otherwise; sound_model_57 SHALL be 1 in CHIME and 0 otherwise; snooze_pend_57 SHALL be 1 only in SNOOZE.

Reset
REQ-033 rst_57 high SHALL asynchronously force IDLE, count=0, snooze_cnt=0, key-edge registers=0, and all outputs 0, including when asserted mid-burst.
REQ-034 After rst_57 deasserts, the first trigger SHALL be honoured on the first tick that satisfies it.

Verification
REQ-035 Time 09:59:59 -> 10:00:00 tick, alarm_en=0 -> sound_e=1 and model=1 one clock later, for 8 ticks, then sound_e=0.
REQ-036 Alarm 07:30, time reaches 07:30:00 -> sound_e=1, model=0; no keys -> sound_e falls after 60 ticks.
REQ-037 Alarm 08:00 at 08:00:00 (coincides with chime) -> ALARM, model=0; chime never asserted.
REQ-038 In ALARM, press snooze 4 times across re-rings with MAX_SNOOZE=3 -> 3 SNOOZE periods of 300 ticks, each ending in ALARM with sound_e=1; 4th press ignored.
REQ-039 In ALARM, stop and snooze rise in the same cycle -> IDLE, snooze_pend=0; separately, alarm_en dropped in SNOOZE -> IDLE.
REQ-040 rst_57 pulsed mid-CHIME, asynchronously to clk -> outputs 0 immediately, and no sound until the next trigger.
